// File: rtl/mem_access_stage.sv
// MEM stage of the 5-stage pipeline: runs the data-memory req/ack handshake for LW/SW,
// stalls upstream while an access is outstanding and strobes the result into MEM_WB.
module mem_access_stage #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        valid_in,
    input  logic [31:0] ir_in,
    input  logic [31:0] alu_in,
    input  logic [31:0] rt_in,
    input  logic [31:0] pc_in,
    output logic        stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        wb_write_en,
    output logic [31:0] ir_out,
    output logic [31:0] lmd_out,
    output logic [31:0] alureg_out,
    output logic [31:0] pc_out,
    output logic        bus_err
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [5:0] OP_LW = 6'b100011;
    localparam logic [5:0] OP_SW = 6'b101011;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          req_q, req_d;
    logic          we_q, we_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   cap_ir_q, cap_ir_d;
    logic [31:0]   cap_pc_q, cap_pc_d;
    logic          wb_q, wb_d;
    logic [31:0]   ir_out_q, ir_out_d;
    logic [31:0]   lmd_q, lmd_d;
    logic [31:0]   alureg_q, alureg_d;
    logic [31:0]   pc_out_q, pc_out_d;
    logic          err_q, err_d;

    logic is_lw_s;
    logic is_sw_s;

    assign is_lw_s = (ir_in[31:26] == OP_LW);
    assign is_sw_s = (ir_in[31:26] == OP_SW);

    // Next-state and next-output computation for the IDLE/ACCESS handshake FSM.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        req_d    = req_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        cap_ir_d = cap_ir_q;
        cap_pc_d = cap_pc_q;
        wb_d     = 1'b0;
        ir_out_d = ir_out_q;
        lmd_d    = lmd_q;
        alureg_d = alureg_q;
        pc_out_d = pc_out_q;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                if (valid_in) begin
                    if (is_lw_s || is_sw_s) begin
                        if (alu_in[1:0] != 2'b00) begin
                            // Misaligned: retire as a NOP without touching memory.
                            err_d    = 1'b1;
                            wb_d     = 1'b1;
                            ir_out_d = 32'h0000_0000;
                            lmd_d    = 32'h0000_0000;
                            alureg_d = alu_in;
                            pc_out_d = pc_in;
                        end else begin
                            state_d  = ACCESS;
                            req_d    = 1'b1;
                            we_d     = is_sw_s;
                            addr_d   = alu_in;
                            wdata_d  = rt_in;
                            cnt_d    = {CW{1'b0}};
                            cap_ir_d = ir_in;
                            cap_pc_d = pc_in;
                        end
                    end else begin
                        wb_d     = 1'b1;
                        ir_out_d = ir_in;
                        lmd_d    = 32'h0000_0000;
                        alureg_d = alu_in;
                        pc_out_d = pc_in;
                    end
                end else begin
                    wb_d = 1'b0;
                end
            end
            ACCESS: begin
                if (dmem_ack) begin
                    state_d  = IDLE;
                    req_d    = 1'b0;
                    wb_d     = 1'b1;
                    ir_out_d = cap_ir_q;
                    lmd_d    = we_q ? 32'h0000_0000 : dmem_rdata;
                    alureg_d = addr_q;
                    pc_out_d = cap_pc_q;
                end else if (cnt_q == CNT_LAST) begin
                    state_d  = IDLE;
                    req_d    = 1'b0;
                    err_d    = 1'b1;
                    wb_d     = 1'b1;
                    ir_out_d = 32'h0000_0000;
                    lmd_d    = 32'h0000_0000;
                    alureg_d = addr_q;
                    pc_out_d = cap_pc_q;
                end else begin
                    cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (resetn) begin
            state_q  <= IDLE;
            cnt_q    <= {CW{1'b0}};
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= 32'h0000_0000;
            wdata_q  <= 32'h0000_0000;
            cap_ir_q <= 32'h0000_0000;
            cap_pc_q <= 32'h0000_0000;
            wb_q     <= 1'b0;
            ir_out_q <= 32'h0000_0000;
            lmd_q    <= 32'h0000_0000;
            alureg_q <= 32'h0000_0000;
            pc_out_q <= 32'h0000_0000;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            req_q    <= req_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            cap_ir_q <= cap_ir_d;
            cap_pc_q <= cap_pc_d;
            wb_q     <= wb_d;
            ir_out_q <= ir_out_d;
            lmd_q    <= lmd_d;
            alureg_q <= alureg_d;
            pc_out_q <= pc_out_d;
            err_q    <= err_d;
        end
    end

    assign stall       = (state_q == ACCESS);
    assign dmem_req    = req_q;
    assign dmem_we     = we_q;
    assign dmem_addr   = addr_q;
    assign dmem_wdata  = wdata_q;
    assign wb_write_en = wb_q;
    assign ir_out      = ir_out_q;
    assign lmd_out     = lmd_q;
    assign alureg_out  = alureg_q;
    assign pc_out      = pc_out_q;
    assign bus_err     = err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: stimulus pushes expected MEM_WB records,
// a negedge monitor pops and compares on every wb_write_en strobe.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic        valid_in = 1'b0;
    logic [31:0] ir_in = 32'h0, alu_in = 32'h0, rt_in = 32'h0, pc_in = 32'h0;
    logic        stall, dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [31:0] dmem_rdata = 32'h0;
    logic        dmem_ack = 1'b0;
    logic        wb_write_en, bus_err;
    logic [31:0] ir_out, lmd_out, alureg_out, pc_out;

    typedef struct packed {
        logic [31:0] ir;
        logic [31:0] lmd;
        logic [31:0] alu;
        logic [31:0] pc;
    } wb_t;

    wb_t exp_q[$];
    int  n_checks = 0;
    int  n_pass = 0;
    bit  done = 1'b0;

    mem_access_stage #(.TIMEOUT(16)) dut (
        .clk(clk), .resetn(resetn), .valid_in(valid_in),
        .ir_in(ir_in), .alu_in(alu_in), .rt_in(rt_in), .pc_in(pc_in),
        .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .wb_write_en(wb_write_en), .ir_out(ir_out), .lmd_out(lmd_out),
        .alureg_out(alureg_out), .pc_out(pc_out), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor: every write-back strobe must match the oldest expected record.
    always @(negedge clk) begin
        if (wb_write_en === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL wb_unexpected: got ir=%h pc=%h expected no strobe", ir_out, pc_out);
            end else begin
                wb_t e;
                e = exp_q.pop_front();
                if ({ir_out, lmd_out, alureg_out, pc_out} === e) n_pass++;
                else $display("FAIL wb_record: got ir=%h lmd=%h alu=%h pc=%h expected ir=%h lmd=%h alu=%h pc=%h",
                              ir_out, lmd_out, alureg_out, pc_out, e.ir, e.lmd, e.alu, e.pc);
            end
        end
    end

    task automatic issue(input logic [31:0] ir, input logic [31:0] alu,
                         input logic [31:0] rt, input logic [31:0] pc);
        @(negedge clk);
        valid_in = 1'b1; ir_in = ir; alu_in = alu; rt_in = rt; pc_in = pc;
        @(posedge clk); #1;
        valid_in = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk); #1;
        resetn = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int cnt;
        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req", {31'h0, dmem_req}, 32'h0);
        chk("rst_stall", {31'h0, stall}, 32'h0);
        chk("rst_wb", {31'h0, wb_write_en}, 32'h0);
        chk("rst_err", {31'h0, bus_err}, 32'h0);
        chk("rst_ir_out", ir_out, 32'h0);
        resetn = 1'b0;

        // 1. ALU op, one-cycle latency
        exp_q.push_back({32'h012A4020, 32'h0, 32'h5, 32'h10});
        issue(32'h012A4020, 32'h5, 32'h0, 32'h10);
        @(negedge clk);
        chk("t1_wb", {31'h0, wb_write_en}, 32'h1);
        chk("t1_stall", {31'h0, stall}, 32'h0);

        // 2. LW acked in third access cycle
        exp_q.push_back({32'h8D090000, 32'hCAFE0001, 32'h100, 32'h20});
        issue(32'h8D090000, 32'h100, 32'h0, 32'h20);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t2_req", {31'h0, dmem_req}, 32'h1);
            chk("t2_stall", {31'h0, stall}, 32'h1);
            if (i == 2) begin
                chk("t2_addr", dmem_addr, 32'h100);
                chk("t2_we", {31'h0, dmem_we}, 32'h0);
                dmem_ack = 1'b1; dmem_rdata = 32'hCAFE0001;
            end
        end
        @(posedge clk); #1;
        dmem_ack = 1'b0; dmem_rdata = 32'h0;
        @(negedge clk);
        chk("t2_req_drop", {31'h0, dmem_req}, 32'h0);
        chk("t2_stall_drop", {31'h0, stall}, 32'h0);

        // 3. SW acked in second access cycle, store data held
        exp_q.push_back({32'hAC0A0004, 32'h0, 32'h104, 32'h24});
        issue(32'hAC0A0004, 32'h104, 32'h55, 32'h24);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("t3_we", {31'h0, dmem_we}, 32'h1);
            chk("t3_wdata", dmem_wdata, 32'h55);
            chk("t3_addr", dmem_addr, 32'h104);
            if (i == 1) begin
                dmem_ack = 1'b1; dmem_rdata = 32'hDEADBEEF;
            end
        end
        @(posedge clk); #1;
        dmem_ack = 1'b0;

        // 4. LW with no ack aborts after 16 access cycles
        exp_q.push_back({32'h0, 32'h0, 32'h200, 32'h30});
        issue(32'h8C0B0000, 32'h200, 32'h0, 32'h30);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (dmem_req !== 1'b1) break;
            cnt++;
        end
        chk("t4_req_cycles", cnt, 32'd16);
        chk("t4_err", {31'h0, bus_err}, 32'h1);
        exp_q.push_back({32'h01095020, 32'h0, 32'h7, 32'h34});
        issue(32'h01095020, 32'h7, 32'h0, 32'h34);
        @(negedge clk);
        chk("t4_next_alu_wb", {31'h0, wb_write_en}, 32'h1);

        // 5. Misaligned LW
        do_reset();
        @(negedge clk);
        chk("t5_err_cleared", {31'h0, bus_err}, 32'h0);
        exp_q.push_back({32'h0, 32'h0, 32'h102, 32'h40});
        issue(32'h8C0C0000, 32'h102, 32'h0, 32'h40);
        @(negedge clk);
        chk("t5_req", {31'h0, dmem_req}, 32'h0);
        chk("t5_err", {31'h0, bus_err}, 32'h1);
        chk("t5_stall", {31'h0, stall}, 32'h0);

        // 6a. Reset during access; late ack ignored
        do_reset();
        issue(32'h8C0D0000, 32'h300, 32'h0, 32'h44);
        repeat (2) @(negedge clk);
        chk("t6_req_pre", {31'h0, dmem_req}, 32'h1);
        resetn = 1'b1;
        @(posedge clk); #1;
        resetn = 1'b0;
        dmem_ack = 1'b1; dmem_rdata = 32'h11111111;
        @(negedge clk);
        chk("t6_req_rst", {31'h0, dmem_req}, 32'h0);
        chk("t6_stall_rst", {31'h0, stall}, 32'h0);
        chk("t6_wb_rst", {31'h0, wb_write_en}, 32'h0);
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        @(negedge clk);
        chk("t6_late_ack_wb", {31'h0, wb_write_en}, 32'h0);
        chk("t6_late_ack_stall", {31'h0, stall}, 32'h0);

        // 6b. Ack in the last access cycle wins over timeout
        exp_q.push_back({32'h8C0E0000, 32'h12345678, 32'h400, 32'h50});
        issue(32'h8C0E0000, 32'h400, 32'h0, 32'h50);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (i == 15) begin
                dmem_ack = 1'b1; dmem_rdata = 32'h12345678;
            end
        end
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        @(negedge clk);
        chk("t6_ack_at_timeout_err", {31'h0, bus_err}, 32'h0);
        chk("t6_ack_at_timeout_req", {31'h0, dmem_req}, 32'h0);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 32'd0);
        done = 1'b1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
